data_mem_server: RTL and testbench

- Memory-side responder for a core's per-thread data memory interface. Serves NUM_LANES independent read and write request channels, each using a valid/ready 4-phase handshake, from one internal single-port storage array.
- A round-robin arbiter issues at most one storage access per cycle. Each access has a fixed response latency.
- Used as the data memory model in core- and GPU-level benches, and as the synthesizable on-chip data RAM for small configurations.

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/data_mem_server.sv | 160 ++++++++++++++++
 tb/tb_data_mem_server.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the multi-lane data memory responder.
// Lane FSM states, access kinds and the latency counter width.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } lane_state_t;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_kind_t;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_BITS = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// rotating pointer; the pointer moves past the winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] request,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value held and no latch is inferred.
    always_comb begin : search
        logic [PTR_W-1:0] idx;
        grant       = '0;
        grant_valid = 1'b0;
        ptr_d       = ptr_q;
        idx         = '0;
        if (enable) begin
            for (int i = 0; i < N; i++) begin
                idx = PTR_W'((int'(ptr_q) + i) % N);
                if (!grant_valid && request[idx]) begin
                    grant[idx]  = 1'b1;
                    grant_valid = 1'b1;
                    ptr_d       = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/data_mem_server.sv
// Multi-lane data memory responder: per-lane valid/ready FSMs sharing one
// single-port storage array through a round-robin arbiter.
module data_mem_server
    import data_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int NUM_LANES = 4,
    parameter int LATENCY   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           data_mem_read_valid,
    input  logic [NUM_LANES*ADDR_BITS-1:0] data_mem_read_address,
    output logic [NUM_LANES-1:0]           data_mem_read_ready,
    output logic [NUM_LANES*DATA_BITS-1:0] data_mem_read_data,
    input  logic [NUM_LANES-1:0]           data_mem_write_valid,
    input  logic [NUM_LANES*ADDR_BITS-1:0] data_mem_write_address,
    input  logic [NUM_LANES*DATA_BITS-1:0] data_mem_write_data,
    output logic [NUM_LANES-1:0]           data_mem_write_ready,
    input  logic                           init_write_enable,
    input  logic [ADDR_BITS-1:0]           init_address,
    input  logic [DATA_BITS-1:0]           init_data,
    output logic                           busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [CNT_BITS-1:0] LAT_M1 = CNT_BITS'(LATENCY - 1);

    lane_state_t          state_q     [NUM_LANES];
    lane_state_t          state_d     [NUM_LANES];
    logic [CNT_BITS-1:0]  count_q     [NUM_LANES];
    logic [CNT_BITS-1:0]  count_d     [NUM_LANES];
    acc_kind_t            kind_q      [NUM_LANES];
    acc_kind_t            kind_d      [NUM_LANES];
    logic [DATA_BITS-1:0] read_data_q [NUM_LANES];
    logic [DATA_BITS-1:0] read_data_d [NUM_LANES];
    logic [DATA_BITS-1:0] storage_q   [DEPTH];

    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic [NUM_LANES-1:0] lane_req;
    logic [NUM_LANES-1:0] grant;
    logic                 grant_valid;

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_req[l] = (state_q[l] == IDLE) &&
                          (data_mem_read_valid[l] || data_mem_write_valid[l]);
        end
    end

    rr_arbiter #(.N(NUM_LANES)) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .enable      (1'b1),
        .request     (lane_req),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // The granted access executes at the grant edge; only one lane can drive
    // the storage write port in a cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            state_d[l]     = state_q[l];
            count_d[l]     = count_q[l];
            kind_d[l]      = kind_q[l];
            read_data_d[l] = read_data_q[l];
            case (state_q[l])
                IDLE: begin
                    if (grant_valid && grant[l]) begin
                        // A write wins over a read raised on the same lane.
                        if (data_mem_write_valid[l]) begin
                            kind_d[l] = ACC_WRITE;
                            wr_en     = 1'b1;
                            wr_addr   = data_mem_write_address[l*ADDR_BITS +: ADDR_BITS];
                            wr_data   = data_mem_write_data[l*DATA_BITS +: DATA_BITS];
                        end else begin
                            kind_d[l]      = ACC_READ;
                            read_data_d[l] =
                                storage_q[data_mem_read_address[l*ADDR_BITS +: ADDR_BITS]];
                        end
                        if (LATENCY == 1) begin
                            state_d[l] = RESPOND;
                        end else begin
                            state_d[l] = WAIT;
                            count_d[l] = LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    count_d[l] = count_q[l] - 1'b1;
                    if (count_q[l] <= CNT_BITS'(1)) begin
                        state_d[l] = RESPOND;
                    end
                end
                RESPOND: begin
                    if (kind_q[l] == ACC_WRITE) begin
                        if (!data_mem_write_valid[l]) state_d[l] = IDLE;
                    end else begin
                        if (!data_mem_read_valid[l]) state_d[l] = IDLE;
                    end
                end
                default: state_d[l] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                state_q[l]     <= IDLE;
                count_q[l]     <= '0;
                kind_q[l]      <= ACC_READ;
                read_data_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                state_q[l]     <= state_d[l];
                count_q[l]     <= count_d[l];
                kind_q[l]      <= kind_d[l];
                read_data_q[l] <= read_data_d[l];
            end
        end
    end

    // NOTE: the array is cleared on reset, which forces a flop implementation;
    // a RAM macro could not honour that clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                storage_q[a] <= '0;
            end
        end else begin
            if (wr_en) begin
                storage_q[wr_addr] <= wr_data;
            end
            // Later assignment wins, so the preload port overrides a lane write.
            if (init_write_enable) begin
                storage_q[init_address] <= init_data;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            data_mem_read_ready[l]  = (state_q[l] == RESPOND) && (kind_q[l] == ACC_READ);
            data_mem_write_ready[l] = (state_q[l] == RESPOND) && (kind_q[l] == ACC_WRITE);
            data_mem_read_data[l*DATA_BITS +: DATA_BITS] = read_data_q[l];
            busy = busy | (state_q[l] != IDLE);
        end
    end

endmodule

// File: tb/tb_data_mem_server.sv
// Directed bench for data_mem_server with a response scoreboard: expected
// responses are queued at request time and retired when ready rises.
module tb_data_mem_server;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NL  = 4;
    localparam int LAT = 2;

    typedef struct {
        int         lane;
        bit         wr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [NL-1:0]  rv, wv;
    logic [NL*AB-1:0] raddr, waddr;
    logic [NL*DB-1:0] wdata;
    logic [NL-1:0]  rready, wready;
    logic [NL*DB-1:0] rdata;
    logic           init_we;
    logic [AB-1:0]  init_addr;
    logic [DB-1:0]  init_dat;
    logic           busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_mem_server #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .NUM_LANES (NL),
        .LATENCY   (LAT)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .data_mem_read_valid    (rv),
        .data_mem_read_address  (raddr),
        .data_mem_read_ready    (rready),
        .data_mem_read_data     (rdata),
        .data_mem_write_valid   (wv),
        .data_mem_write_address (waddr),
        .data_mem_write_data    (wdata),
        .data_mem_write_ready   (wready),
        .init_write_enable      (init_we),
        .init_address           (init_addr),
        .init_data              (init_dat),
        .busy                   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start();
        step();
        cyc = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rv    = '0;
        wv    = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        init_we   = 1'b1;
        init_addr = a;
        init_dat  = d;
        step();
        init_we   = 1'b0;
    endtask

    task automatic issue_read(input int l, input logic [7:0] a, input logic [7:0] d, input int c);
        raddr[l*AB +: AB] = a;
        rv[l] = 1'b1;
        sb.push_back('{l, 1'b0, d, c});
    endtask

    task automatic issue_write(input int l, input logic [7:0] a, input logic [7:0] d, input int c);
        waddr[l*AB +: AB] = a;
        wdata[l*DB +: DB] = d;
        wv[l] = 1'b1;
        sb.push_back('{l, 1'b1, 8'h00, c});
    endtask

    // Retire the oldest queued response for this lane/kind and release valid.
    task automatic retire(input int l, input bit wr);
        int idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].lane == l && sb[i].wr == wr) idx = i;
        end
        check($sformatf("L%0d_%s_expected", l, wr ? "wr" : "rd"), 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
            check($sformatf("L%0d_%s_cycle", l, wr ? "wr" : "rd"), 32'(cyc), 32'(sb[idx].cyc));
            if (!wr) check($sformatf("L%0d_rd_data", l), 32'(rdata[l*DB +: DB]), 32'(sb[idx].data));
            sb.delete(idx);
        end
        if (wr) wv[l] = 1'b0;
        else    rv[l] = 1'b0;
    endtask

    task automatic service(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
            for (int l = 0; l < NL; l++) begin
                if (rready[l] && rv[l]) retire(l, 1'b0);
                if (wready[l] && wv[l]) retire(l, 1'b1);
            end
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        rv = '0;
        wv = '0;
    endtask

    task automatic settle(input string tag);
        step();
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'({rready, wready}), 32'd0);
    endtask

    // Single read whose valid is held 'hold' cycles past ready.
    task automatic hold_read(input string tag, input int l, input logic [7:0] a,
                             input logic [7:0] d, input int hold);
        int   n = 0;
        exp_t e;
        start();
        issue_read(l, a, d, LAT);
        while (!rready[l] && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready_seen"}, 32'(rready[l]), 32'd1);
        e = sb.pop_front();
        check({tag, "_ready_cycle"}, 32'(cyc), 32'(e.cyc));
        check({tag, "_data"}, 32'(rdata[l*DB +: DB]), 32'(e.data));
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_ready_held"}, 32'(rready[l]), 32'd1);
            check({tag, "_data_stable"}, 32'(rdata[l*DB +: DB]), 32'(d));
            check({tag, "_busy_held"}, 32'(busy), 32'd1);
        end
        rv[l] = 1'b0;
        step();
        check({tag, "_ready_drop"}, 32'(rready[l]), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
        init_we = 1'b0; init_addr = '0; init_dat = '0;
        do_reset();
        check("reset_read_ready", 32'(rready), 32'd0);
        check("reset_write_ready", 32'(wready), 32'd0);
        check("reset_read_data", rdata, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Preloaded word read back; valid held one cycle past ready.
        preload(8'h10, 8'hA5);
        hold_read("t1", 0, 8'h10, 8'hA5, 1);

        // Four simultaneous reads from pointer 0, then again after the wrap.
        do_reset();
        preload(8'h01, 8'h11);
        preload(8'h02, 8'h22);
        preload(8'h03, 8'h33);
        preload(8'h04, 8'h44);
        preload(8'h10, 8'hA5);
        start();
        for (int l = 0; l < NL; l++) issue_read(l, 8'(l + 1), 8'(8'h11 * (l + 1)), LAT + l);
        service(30);
        settle("t2a");
        start();
        for (int l = 0; l < NL; l++) issue_read(l, 8'(NL - l), 8'(8'h11 * (NL - l)), LAT + l);
        service(30);
        settle("t2b");

        // Write by lane 1 observed by lane 2.
        start();
        issue_write(1, 8'h20, 8'h3C, LAT);
        service(20);
        settle("t3a");
        start();
        issue_read(2, 8'h20, 8'h3C, LAT);
        service(20);
        settle("t3b");
        // Pointer now sits at lane 3: its read is granted before lane 0's write.
        start();
        issue_write(0, 8'h20, 8'h55, LAT + 1);
        issue_read(3, 8'h20, 8'h3C, LAT);
        service(20);
        settle("t3c");
        start();
        issue_read(1, 8'h20, 8'h55, LAT);
        service(20);
        settle("t3d");

        // Same lane raises write and read: write first, read sees it.
        start();
        issue_write(0, 8'h05, 8'h77, LAT);
        issue_read(0, 8'h05, 8'h77, 5);
        service(30);
        settle("t4");

        // Valid held ten cycles past ready.
        hold_read("t5", 2, 8'h03, 8'h33, 10);

        // Reset while lane 2 waits on a write: aborted and storage cleared.
        start();
        waddr[2*AB +: AB] = 8'h40;
        wdata[2*DB +: DB] = 8'h99;
        wv[2] = 1'b1;
        step();
        check("t6_busy_in_wait", 32'(busy), 32'd1);
        check("t6_no_ready_in_wait", 32'(wready[2]), 32'd0);
        reset = 1'b0;
        wv    = '0;
        step();
        reset = 1'b1;
        check("t6_ready_after_reset", 32'({rready, wready}), 32'd0);
        check("t6_busy_after_reset", 32'(busy), 32'd0);
        check("t6_data_after_reset", rdata, 32'd0);
        start();
        issue_read(2, 8'h40, 8'h00, LAT);
        service(20);
        settle("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
